// File: rtl/rst_domain_sequencer_pkg.sv
// Shared state encodings and default sizing for the reset-domain sequencer.
package rst_domain_sequencer_pkg;

  typedef enum logic [2:0] {
    S_DELAY = 3'd0,
    S_WAIT  = 3'd1,
    S_RUN   = 3'd2,
    S_SHUT  = 3'd3,
    S_FAULT = 3'd4
  } state_e;

  localparam int DEF_N_DOM     = 4;
  localparam int DEF_STAGE_DLY = 16;
  localparam int DEF_TIMEOUT   = 255;
  localparam int DEF_CNT_W     = 8;
  localparam int DEF_IDX_W     = 2;

endpackage

// File: rtl/rst_domain_sequencer_sync.sv
// Active-low reset bridge: asserts asynchronously, releases after two clock edges.
// No data path, so no latency or backpressure beyond the two-edge release.
module rst_n_synch_bridge (
  input  logic clk_i,
  input  logic rst_n_i,
  output logic rst_n_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
    end
  end

  assign rst_n_o = sync_q[1];

endmodule

// File: rtl/rst_domain_sequencer.sv
// Ordered reset-release controller: settle, release, await ready per domain in index order.
// All outputs registered; restart re-asserts domains high-to-low, one per cycle.
module rst_domain_sequencer
  import rst_domain_sequencer_pkg::*;
#(
  parameter int N_DOM     = DEF_N_DOM,
  parameter int STAGE_DLY = DEF_STAGE_DLY,
  parameter int TIMEOUT   = DEF_TIMEOUT,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int IDX_W     = DEF_IDX_W
) (
  input  logic             CLK,
  input  logic             I_RST_N,
  input  logic             I_SW_RST,
  input  logic [N_DOM-1:0] I_DOM_RDY,
  output logic [N_DOM-1:0] O_DOM_RST,
  output logic             O_ALL_RDY,
  output logic             O_BUSY,
  output logic             O_FAULT,
  output logic [IDX_W-1:0] O_STAGE
);

  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(STAGE_DLY - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DOM - 1);

  logic rst_n;

  rst_n_synch_bridge u_rst_sync (
    .clk_i   (CLK),
    .rst_n_i (I_RST_N),
    .rst_n_o (rst_n)
  );

  state_e             state_q,   state_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic [IDX_W-1:0]   idx_q,     idx_d;
  logic [N_DOM-1:0]   dom_rst_q, dom_rst_d;
  logic               all_rdy_q, all_rdy_d;
  logic               busy_q,    busy_d;
  logic               fault_q,   fault_d;

  logic               fail_vld;
  logic [IDX_W-1:0]   fail_idx;

  // Lowest-numbered domain whose ready has dropped; only consulted in RUN.
  always_comb begin
    fail_vld = 1'b0;
    fail_idx = '0;
    for (int i = N_DOM - 1; i >= 0; i--) begin
      if (!I_DOM_RDY[i]) begin
        fail_vld = 1'b1;
        fail_idx = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_DELAY;
      cnt_q     <= '0;
      idx_q     <= '0;
      dom_rst_q <= '1;
      all_rdy_q <= 1'b0;
      busy_q    <= 1'b1;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      dom_rst_q <= dom_rst_d;
      all_rdy_q <= all_rdy_d;
      busy_q    <= busy_d;
      fault_q   <= fault_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    dom_rst_d = dom_rst_q;
    all_rdy_d = all_rdy_q;
    busy_d    = busy_q;
    fault_d   = fault_q;

    unique case (state_q)
      S_DELAY: begin
        if (cnt_q == DLY_LAST) begin
          dom_rst_d[idx_q] = 1'b0;
          cnt_d            = '0;
          state_d          = S_WAIT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_WAIT: begin
        if (I_DOM_RDY[idx_q]) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d   = S_RUN;
            all_rdy_d = 1'b1;
            busy_d    = 1'b0;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_DELAY;
          end
        end else if (cnt_q == TO_LAST) begin
          // idx is kept so O_STAGE names the domain that never came up.
          state_d   = S_FAULT;
          cnt_d     = '0;
          fault_d   = 1'b1;
          dom_rst_d = '1;
          all_rdy_d = 1'b0;
          busy_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_RUN: begin
        if (I_SW_RST) begin
          state_d   = S_SHUT;
          idx_d     = IDX_LAST;
          all_rdy_d = 1'b0;
          busy_d    = 1'b1;
        end else if (fail_vld) begin
          state_d   = S_FAULT;
          idx_d     = fail_idx;
          fault_d   = 1'b1;
          dom_rst_d = '1;
          all_rdy_d = 1'b0;
          busy_d    = 1'b0;
        end
      end

      S_SHUT: begin
        dom_rst_d[idx_q] = 1'b1;
        if (idx_q == '0) begin
          cnt_d   = '0;
          state_d = S_DELAY;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end

      S_FAULT: begin
        dom_rst_d = '1;
        all_rdy_d = 1'b0;
        busy_d    = 1'b0;
        if (I_SW_RST) begin
          fault_d = 1'b0;
          idx_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_DELAY;
        end
      end

      default: begin
        state_d   = S_DELAY;
        cnt_d     = '0;
        idx_d     = '0;
        dom_rst_d = '1;
        all_rdy_d = 1'b0;
        busy_d    = 1'b1;
      end
    endcase
  end

  assign O_DOM_RST = dom_rst_q;
  assign O_ALL_RDY = all_rdy_q;
  assign O_BUSY    = busy_q;
  assign O_FAULT   = fault_q;
  assign O_STAGE   = idx_q;

endmodule

// File: tb/tb_rst_domain_sequencer.sv
// Directed bench for rst_domain_sequencer at default parameters.
module tb_rst_domain_sequencer;

  logic       CLK = 1'b0;
  logic       I_RST_N;
  logic       I_SW_RST;
  logic [3:0] I_DOM_RDY;
  logic [3:0] O_DOM_RST;
  logic       O_ALL_RDY;
  logic       O_BUSY;
  logic       O_FAULT;
  logic [1:0] O_STAGE;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 CLK = ~CLK;

  rst_domain_sequencer dut (
    .CLK       (CLK),
    .I_RST_N   (I_RST_N),
    .I_SW_RST  (I_SW_RST),
    .I_DOM_RDY (I_DOM_RDY),
    .O_DOM_RST (O_DOM_RST),
    .O_ALL_RDY (O_ALL_RDY),
    .O_BUSY    (O_BUSY),
    .O_FAULT   (O_FAULT),
    .O_STAGE   (O_STAGE)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic goto(input int n);
    while (cyc < n) tick();
  endtask

  // Domain k is released at cycle 16 + 17*k when every ready is already high.
  function automatic logic [3:0] exp_rst(input int r);
    logic [3:0] v;
    for (int k = 0; k < 4; k++) v[k] = (r >= 16 + 17 * k) ? 1'b0 : 1'b1;
    return v;
  endfunction

  task automatic seq_run(input string tag, input int last, input int p1, input int p2);
    for (int r = 0; r <= last; r++) begin
      chk($sformatf("%s_rst@%0d", tag, r), 32'(O_DOM_RST), 32'(exp_rst(r)));
      chk($sformatf("%s_allrdy@%0d", tag, r), 32'(O_ALL_RDY), 32'(r >= 68));
      chk($sformatf("%s_busy@%0d", tag, r), 32'(O_BUSY), 32'(r < 68));
      I_SW_RST = (r == p1 || r == p2);
      tick();
      I_SW_RST = 1'b0;
    end
  endtask

  initial begin
    I_RST_N   = 1'b0;
    I_SW_RST  = 1'b0;
    I_DOM_RDY = 4'hF;
    tick();
    tick();
    chk("rst_dom", 32'(O_DOM_RST), 32'hF);
    chk("rst_allrdy", 32'(O_ALL_RDY), 32'h0);
    chk("rst_busy", 32'(O_BUSY), 32'h1);
    chk("rst_fault", 32'(O_FAULT), 32'h0);
    chk("rst_stage", 32'(O_STAGE), 32'h0);

    I_RST_N = 1'b1;
    tick();
    tick();
    cyc = 0;
    seq_run("t1", 70, -1, -1);

    // Software restart from RUN: reverse-order re-assert, then a full resequence.
    I_SW_RST = 1'b1;
    tick();
    I_SW_RST = 1'b0;
    chk("t3_allrdy_drop", 32'(O_ALL_RDY), 32'h0);
    chk("t3_busy", 32'(O_BUSY), 32'h1);
    chk("t3_rst0", 32'(O_DOM_RST), 32'h0);
    tick(); chk("t3_rst8", 32'(O_DOM_RST), 32'h8);
    tick(); chk("t3_rstC", 32'(O_DOM_RST), 32'hC);
    tick(); chk("t3_rstE", 32'(O_DOM_RST), 32'hE);
    tick(); chk("t3_rstF", 32'(O_DOM_RST), 32'hF);
    cyc = 0;
    seq_run("t3", 70, -1, -1);

    // Lost ready in RUN.
    I_DOM_RDY = 4'b1101;
    tick();
    chk("t4_fault", 32'(O_FAULT), 32'h1);
    chk("t4_stage", 32'(O_STAGE), 32'h1);
    chk("t4_rst", 32'(O_DOM_RST), 32'hF);
    chk("t4_allrdy", 32'(O_ALL_RDY), 32'h0);
    chk("t4_busy", 32'(O_BUSY), 32'h0);
    I_DOM_RDY = 4'hF;
    tick();
    tick();
    chk("t4_sticky", 32'(O_FAULT), 32'h1);
    chk("t4_stage_frozen", 32'(O_STAGE), 32'h1);
    I_SW_RST = 1'b1;
    tick();
    I_SW_RST = 1'b0;
    cyc = 0;
    chk("t4_clr_fault", 32'(O_FAULT), 32'h0);
    chk("t4_clr_busy", 32'(O_BUSY), 32'h1);
    chk("t4_clr_stage", 32'(O_STAGE), 32'h0);
    goto(15); chk("t4_d0_held", 32'(O_DOM_RST), 32'hF);
    goto(16); chk("t4_d0_rel", 32'(O_DOM_RST), 32'hE);

    // Domain 2 never reports ready: timeout after 255 WAIT cycles.
    goto(20);
    I_DOM_RDY = 4'b1011;
    goto(49);  chk("t2_pre_rel", 32'(O_DOM_RST), 32'hC);
    goto(50);  chk("t2_rel", 32'(O_DOM_RST), 32'h8);
    chk("t2_stage_wait", 32'(O_STAGE), 32'h2);
    goto(304); chk("t2_nofault", 32'(O_FAULT), 32'h0);
    chk("t2_rst_304", 32'(O_DOM_RST), 32'h8);
    chk("t2_busy_304", 32'(O_BUSY), 32'h1);
    goto(305); chk("t2_fault", 32'(O_FAULT), 32'h1);
    chk("t2_stage", 32'(O_STAGE), 32'h2);
    chk("t2_rst", 32'(O_DOM_RST), 32'hF);
    chk("t2_busy", 32'(O_BUSY), 32'h0);
    chk("t2_allrdy", 32'(O_ALL_RDY), 32'h0);

    // Board reset mid-WAIT on domain 1, between clock edges.
    I_SW_RST = 1'b1;
    tick();
    I_SW_RST = 1'b0;
    cyc = 0;
    I_DOM_RDY = 4'b1101;
    goto(40);
    chk("t5_wait_rst", 32'(O_DOM_RST), 32'hC);
    chk("t5_wait_stage", 32'(O_STAGE), 32'h1);
    #3;
    I_RST_N = 1'b0;
    #1;
    chk("t5_async_rst", 32'(O_DOM_RST), 32'hF);
    chk("t5_async_stage", 32'(O_STAGE), 32'h0);
    chk("t5_async_busy", 32'(O_BUSY), 32'h1);
    chk("t5_async_fault", 32'(O_FAULT), 32'h0);
    I_DOM_RDY = 4'hF;
    tick();
    tick();
    I_RST_N = 1'b1;
    tick();
    chk("t5_edge1_rst", 32'(O_DOM_RST), 32'hF);
    tick();
    cyc = 0;
    // Restart pulses during DELAY must not disturb the timing.
    seq_run("t5t6", 70, 5, 40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
